// File: rtl/serializer.sv
// serializer: WIDTH-bit words in over valid/ready, one bit out per clk_25G cycle (LSB first), one-entry holding buffer.
// Optional SER_UNDERFLOW_CNT_EN adds a 16-bit saturating underflow counter port.
module serializer #(
  parameter int                WIDTH        = 60,
  parameter int                CNT_W        = 6,
  parameter logic [WIDTH-1:0]  IDLE_PATTERN = 60'hAAAAAAAAAAAAAAA
) (
  input  logic             clk_25G,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_parallel,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             data_serial,
  output logic             frame_start,
  output logic             underflow
`ifdef SER_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]      underflow_cnt
`endif
);

  logic [WIDTH-1:0] shift_q;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full;
  logic             started;

  logic accept;
  logic last_bit;
  logic idle_frame;

  assign data_ready  = ~hold_full;
  assign data_serial = shift_q[0];
  assign accept      = data_valid & ~hold_full;
  assign last_bit    = (bit_cnt == CNT_W'(WIDTH - 1));
  // Idle is flagged only once real traffic has been seen.
  assign idle_frame  = last_bit & ~hold_full & ~accept & started;

  always_ff @(posedge clk_25G) begin
    if (!rst_n) begin
      shift_q     <= IDLE_PATTERN;
      bit_cnt     <= '0;
      hold_q      <= '0;
      hold_full   <= 1'b0;
      started     <= 1'b0;
      frame_start <= 1'b1;
      underflow   <= 1'b0;
    end else begin
      underflow <= 1'b0;
      if (accept) begin
        started <= 1'b1;
      end
      if (last_bit) begin
        bit_cnt     <= '0;
        frame_start <= 1'b1;
        if (hold_full) begin
          shift_q   <= hold_q;
          hold_full <= 1'b0;
        end else if (accept) begin
          shift_q <= data_parallel;
        end else begin
          shift_q   <= IDLE_PATTERN;
          underflow <= started;
        end
      end else begin
        bit_cnt     <= bit_cnt + CNT_W'(1);
        frame_start <= 1'b0;
        shift_q     <= shift_q >> 1;
        if (accept) begin
          hold_q    <= data_parallel;
          hold_full <= 1'b1;
        end
      end
    end
  end

`ifdef SER_UNDERFLOW_CNT_EN
  always_ff @(posedge clk_25G) begin
    if (!rst_n) begin
      underflow_cnt <= '0;
    end else if (idle_frame && (underflow_cnt != 16'hFFFF)) begin
      underflow_cnt <= underflow_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_serializer.sv
// Scoreboard bench for serializer: driver queues expected frames, a negedge monitor rebuilds and checks each frame.
module tb_serializer;

  localparam int W = 60;
  localparam logic [W-1:0] IDLE = 60'hAAAAAAAAAAAAAAA;

  typedef struct packed {
    logic [W-1:0] word;
    logic         uf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] data_parallel = '0;
  logic         data_valid = 1'b0;
  logic         data_ready;
  logic         data_serial;
  logic         frame_start;
  logic         underflow;
`ifdef SER_UNDERFLOW_CNT_EN
  logic [15:0]  underflow_cnt;
`endif

  serializer dut (
    .clk_25G       (clk),
    .rst_n         (rst_n),
    .data_parallel (data_parallel),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .data_serial   (data_serial),
    .frame_start   (frame_start),
    .underflow     (underflow)
`ifdef SER_UNDERFLOW_CNT_EN
    ,
    .underflow_cnt (underflow_cnt)
`endif
  );

  always #5 clk = ~clk;

  int   n_vec  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [W-1:0] w, input logic uf);
    exp_t e;
    e.word = w;
    e.uf   = uf;
    exp_q.push_back(e);
  endtask

  // Hold the word on the bus until accepted; report how many cycles ready was low.
  task automatic send(input logic [W-1:0] w, output int low);
    data_parallel = w;
    data_valid    = 1'b1;
    low = 0;
    while (!data_ready && low < 200) begin
      step(1);
      low++;
    end
    chk("send_ready_seen", data_ready, 1'b1);
    step(1);
  endtask

  // Monitor: rebuild each frame LSB first and compare it with the next queued expectation.
  int           bit_idx = 0;
  logic [W-1:0] got = '0;
  exp_t         cur;
  bit           have_cur = 1'b0;
  int           exp_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      bit_idx  = 0;
      have_cur = 1'b0;
      exp_cnt  = 0;
    end else begin
      if (bit_idx == 0) begin
        chk("frame_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          cur      = exp_q.pop_front();
          have_cur = 1'b1;
          if (cur.uf) exp_cnt++;
        end else begin
          have_cur = 1'b0;
        end
        chk("underflow_first_bit", underflow, have_cur ? cur.uf : 1'b0);
`ifdef SER_UNDERFLOW_CNT_EN
        chk("underflow_cnt", underflow_cnt, exp_cnt);
`endif
      end else begin
        chk("underflow_mid_frame", underflow, 1'b0);
      end
      chk("frame_start", frame_start, bit_idx == 0);
      got[bit_idx] = data_serial;
      if (bit_idx == W - 1) begin
        if (have_cur) chk("frame_word", got, cur.word);
        bit_idx = 0;
      end else begin
        bit_idx++;
      end
    end
  end

  initial begin
    #100us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int low;

    // Reset for 3 cycles; five idle frames with no underflow follow.
    for (int i = 0; i < 5; i++) push_frame(IDLE, 1'b0);
    step(3);
    rst_n = 1'b1;
    chk("ready_after_reset", data_ready, 1'b1);

    // Bypass on the boundary cycle of the fifth idle frame.
    step(299);
    chk("ready_before_bypass", data_ready, 1'b1);
    data_parallel = 60'h123456789ABCDEF;
    data_valid    = 1'b1;
    push_frame(60'h123456789ABCDEF, 1'b0);
    step(1);

    // Back-to-back with valid held high; each later word waits out a full frame minus one cycle.
    push_frame(60'hFFFFFFFFFFFFFFF, 1'b0);
    send(60'hFFFFFFFFFFFFFFF, low);
    chk("ready_low_cycles_w1", low, 0);
    push_frame(60'h000000000000001, 1'b0);
    send(60'h000000000000001, low);
    chk("ready_low_cycles_w2", low, 59);
    push_frame(60'h0F0F0F0F0F0F0F0, 1'b0);
    send(60'h0F0F0F0F0F0F0F0, low);
    chk("ready_low_cycles_w3", low, 59);
    data_valid = 1'b0;

    // Starved: idle frames with underflow from here on.
    for (int i = 0; i < 4; i++) push_frame(IDLE, 1'b1);

    // Buffer a word early in an idle frame, then reset at bit 30.
    step(304);
    chk("ready_before_buffer", data_ready, 1'b1);
    data_parallel = 60'hDEADBEEFCAFE123;
    data_valid    = 1'b1;
    step(1);
    data_valid = 1'b0;
    step(24);
    chk("ready_low_while_buffered", data_ready, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    push_frame(IDLE, 1'b0);
    push_frame(IDLE, 1'b0);
    step(2);
    rst_n = 1'b1;
    chk("ready_after_mid_reset", data_ready, 1'b1);
    step(119);
    @(negedge clk);
    #1;
    chk("all_frames_consumed", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
